// File: rtl/music_pkg.sv
// Shared types and constants for the note scheduler and its beat counter.
// Latency: none; this file holds only types and constants.
// Backpressure: none. SCHED_GAP_EN adds the GAP state encoding.
package music_pkg;

  // Default widths for pitch codes and durations (in beats).
  localparam int NOTE_WIDTH_DEF = 6;
  localparam int DUR_WIDTH_DEF  = 6;

  // One beat is 1/48 s.
  localparam int BEATS_PER_SEC  = 48;

  typedef enum logic [2:0] {
    SCHED_IDLE = 3'd0,
    SCHED_LOAD = 3'd1,
    SCHED_PLAY = 3'd2,
    SCHED_DONE = 3'd3
`ifdef SCHED_GAP_EN
    ,
    SCHED_GAP  = 3'd4
`endif
  } sched_state_t;

endpackage

// File: rtl/sched_beat_counter.sv
// Loadable beats-left down-counter paired with a saturating elapsed-beats up-counter.
// Latency: load and count take effect on the next clk edge.
// Backpressure: none; counts whenever the owner enables it.
module sched_beat_counter
  import music_pkg::*;
#(
  parameter int W = DUR_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld_vld,
  input  logic [W-1:0] ld_dat,
  input  logic         clr_up,
  input  logic         dec_en,
  input  logic         inc_en,
  output logic [W-1:0] beats_left,
  output logic [W-1:0] elapsed
);

  logic [W-1:0] down_q, down_d;
  logic [W-1:0] up_q, up_d;

  // Next values: a load wins over a count; the down-counter stops at zero, the up-counter at all-ones.
  always_comb begin
    down_d = down_q;
    up_d   = up_q;
    if (ld_vld) begin
      down_d = ld_dat;
    end else if (dec_en && (down_q != '0)) begin
      down_d = down_q - W'(1);
    end
    if (clr_up) begin
      up_d = '0;
    end else if (inc_en && (up_q != '1)) begin
      up_d = up_q + W'(1);
    end
  end

  // Counter registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      down_q <= '0;
      up_q   <= '0;
    end else begin
      down_q <= down_d;
      up_q   <= up_d;
    end
  end

  assign beats_left = down_q;
  assign elapsed    = up_q;

endmodule

// File: rtl/note_scheduler.sv
// Sequences (pitch, duration) notes into the dynamics path for exactly `duration` beats each.
// Latency: note_load one cycle after the accepting handshake; done_with_note one cycle after the last beat.
// Backpressure: note_in_ready only in IDLE with play=1; SCHED_GAP_EN inserts GAP_BEATS silent beats after each note.
module note_scheduler
  import music_pkg::*;
#(
  parameter int NOTE_WIDTH = NOTE_WIDTH_DEF,
  parameter int DUR_WIDTH  = DUR_WIDTH_DEF,
  parameter int GAP_BEATS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play,
  input  logic                  beat,
  input  logic                  sample_tick,
  input  logic                  note_in_valid,
  output logic                  note_in_ready,
  input  logic [NOTE_WIDTH-1:0] note_in,
  input  logic [DUR_WIDTH-1:0]  duration_in,
  output logic [NOTE_WIDTH-1:0] note_out,
  output logic [DUR_WIDTH-1:0]  duration_out,
  output logic                  note_load,
  output logic                  done_with_note,
  output logic                  generate_next_sample,
  output logic [DUR_WIDTH-1:0]  elapsed_beats,
  output logic                  busy
);

  sched_state_t state_q, state_d;
  logic [NOTE_WIDTH-1:0] note_q, note_d;
  logic [DUR_WIDTH-1:0]  dur_q, dur_d;

  logic                  beat_en;
  logic                  note_hs;
  logic                  note_start;
  logic [DUR_WIDTH-1:0]  beats_left;

  logic                  cnt_ld_vld;
  logic [DUR_WIDTH-1:0]  cnt_ld_dat;
  logic                  cnt_clr_up;
  logic                  cnt_dec_en;
  logic                  cnt_inc_en;

`ifdef SCHED_GAP_EN
  localparam logic [DUR_WIDTH-1:0] GAP_LD = DUR_WIDTH'(GAP_BEATS);
`else
  // Without the gap state the gap length has no consumer.
  logic [31:0] unused_gap_beats;
  assign unused_gap_beats = 32'(GAP_BEATS);
`endif

  // Beats only count while playback runs; a pause freezes both counters.
  assign beat_en = beat && play;

  // Ready is held low while reset is asserted so nothing is taken during the clear.
  assign note_in_ready = reset && play && (state_q == SCHED_IDLE);
  assign note_hs       = note_in_valid && note_in_ready;
  // A zero-duration note is consumed by the handshake but never started.
  assign note_start    = note_hs && (duration_in != '0);

  // State and note registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= SCHED_IDLE;
      note_q  <= '0;
      dur_q   <= '0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      dur_q   <= dur_d;
    end
  end

  // Capture pitch and duration only for notes that will actually play, so outputs hold until the next LOAD.
  always_comb begin
    note_d = note_q;
    dur_d  = dur_q;
    if (note_start) begin
      note_d = note_in;
      dur_d  = duration_in;
    end
  end

  // Next-state: LOAD and DONE always complete; IDLE, PLAY and GAP advance only with play=1.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SCHED_IDLE: if (note_start) state_d = SCHED_LOAD;
      SCHED_LOAD: state_d = SCHED_PLAY;
      SCHED_PLAY: if (beat_en && (beats_left == DUR_WIDTH'(1))) state_d = SCHED_DONE;
`ifdef SCHED_GAP_EN
      SCHED_DONE: state_d = SCHED_GAP;
      SCHED_GAP: begin
        // A zero-length gap still spends exactly one cycle here.
        if ((beats_left == '0) || (beat_en && (beats_left == DUR_WIDTH'(1)))) begin
          state_d = SCHED_IDLE;
        end
      end
`else
      SCHED_DONE: state_d = SCHED_IDLE;
`endif
      default:    state_d = SCHED_IDLE;
    endcase
  end

  // Outputs and counter control per state.
  always_comb begin
    note_load            = 1'b0;
    done_with_note       = 1'b0;
    generate_next_sample = 1'b0;
    busy                 = 1'b1;
    cnt_ld_vld           = 1'b0;
    cnt_ld_dat           = duration_in;
    cnt_clr_up           = 1'b0;
    cnt_dec_en           = 1'b0;
    cnt_inc_en           = 1'b0;
    case (state_q)
      SCHED_IDLE: begin
        busy = 1'b0;
        // Loading at the handshake makes elapsed_beats read 0 during LOAD.
        cnt_ld_vld = note_start;
        cnt_clr_up = note_start;
      end
      SCHED_LOAD: begin
        note_load = 1'b1;
      end
      SCHED_PLAY: begin
        generate_next_sample = sample_tick && play;
        cnt_dec_en           = beat_en;
        cnt_inc_en           = beat_en;
      end
      SCHED_DONE: begin
        done_with_note = 1'b1;
`ifdef SCHED_GAP_EN
        // Reuse the beats-left counter for the gap; elapsed_beats keeps the finished note's count.
        cnt_ld_vld = 1'b1;
        cnt_ld_dat = GAP_LD;
`endif
      end
`ifdef SCHED_GAP_EN
      SCHED_GAP: begin
        cnt_dec_en = beat_en;
      end
`endif
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  sched_beat_counter #(
    .W(DUR_WIDTH)
  ) u_beat_counter (
    .clk        (clk),
    .reset      (reset),
    .ld_vld     (cnt_ld_vld),
    .ld_dat     (cnt_ld_dat),
    .clr_up     (cnt_clr_up),
    .dec_en     (cnt_dec_en),
    .inc_en     (cnt_inc_en),
    .beats_left (beats_left),
    .elapsed    (elapsed_beats)
  );

  assign note_out     = note_q;
  assign duration_out = dur_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: directed scenarios then random stimulus against a timeline reference model.
// The model tracks when each note loads, ends and frees the scheduler, in cycle numbers.
// SCHED_GAP_EN, when defined, adds the gap phase to the model.
module tb_note_scheduler;

  localparam int NW     = 6;
  localparam int DW     = 6;
  localparam int GB     = 2;
  localparam int BIG    = 1 << 30;
  localparam int EL_MAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          play;
  logic          beat;
  logic          sample_tick;
  logic          note_in_valid;
  logic          note_in_ready;
  logic [NW-1:0] note_in;
  logic [DW-1:0] duration_in;
  logic [NW-1:0] note_out;
  logic [DW-1:0] duration_out;
  logic          note_load;
  logic          done_with_note;
  logic          generate_next_sample;
  logic [DW-1:0] elapsed_beats;
  logic          busy;

  note_scheduler #(
    .NOTE_WIDTH(NW),
    .DUR_WIDTH (DW),
    .GAP_BEATS (GB)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .play                 (play),
    .beat                 (beat),
    .sample_tick          (sample_tick),
    .note_in_valid        (note_in_valid),
    .note_in_ready        (note_in_ready),
    .note_in              (note_in),
    .duration_in          (duration_in),
    .note_out             (note_out),
    .duration_out         (duration_out),
    .note_load            (note_load),
    .done_with_note       (done_with_note),
    .generate_next_sample (generate_next_sample),
    .elapsed_beats        (elapsed_beats),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference timeline: cycle numbers of note events plus the current note's contents.
  int cyc      = 0;
  int m_note   = 0;
  int m_dur    = 0;
  int m_el     = 0;
  int m_beats  = 0;
  int load_cyc = -1;
  int done_cyc = -1;
  int free_cyc = 0;
`ifdef SCHED_GAP_EN
  int gap_start = -1;
  int gap_cnt   = 0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit m_playing();
    return (load_cyc >= 0) && (done_cyc < 0) && (cyc > load_cyc);
  endfunction

  function automatic bit m_ready();
    return reset && play && (cyc >= free_cyc);
  endfunction

  task automatic compare_outputs();
    check_eq("ready",    32'(note_in_ready),        32'(m_ready()));
    check_eq("busy",     32'(busy),                 32'(cyc < free_cyc));
    check_eq("load",     32'(note_load),            32'(cyc == load_cyc));
    check_eq("done",     32'(done_with_note),       32'(cyc == done_cyc));
    check_eq("gen",      32'(generate_next_sample), 32'(sample_tick && play && m_playing()));
    check_eq("note_out", 32'(note_out),             32'(m_note));
    check_eq("dur_out",  32'(duration_out),         32'(m_dur));
    check_eq("elapsed",  32'(elapsed_beats),        32'(m_el));
  endtask

  // Advance the reference across the coming clock edge using the inputs now applied.
  task automatic model_step(output bit hs);
    bit playing;
    bit rdy;
    playing = m_playing();
    rdy     = m_ready();
    hs      = 1'b0;
    if (!reset) begin
      m_note = 0; m_dur = 0; m_el = 0; m_beats = 0;
      load_cyc = -1; done_cyc = -1; free_cyc = 0;
`ifdef SCHED_GAP_EN
      gap_start = -1; gap_cnt = 0;
`endif
    end else begin
      if (rdy && note_in_valid) begin
        hs = 1'b1;
        if (duration_in != 0) begin
          m_note = int'(note_in); m_dur = int'(duration_in);
          m_el = 0; m_beats = 0;
          load_cyc = cyc + 1; done_cyc = -1; free_cyc = BIG;
`ifdef SCHED_GAP_EN
          gap_start = -1;
`endif
        end
      end
      if (playing && beat && play) begin
        m_beats++;
        if (m_el < EL_MAX) m_el++;
        if (m_beats == m_dur) begin
          done_cyc = cyc + 1;
`ifdef SCHED_GAP_EN
          gap_start = cyc + 2;
          gap_cnt   = 0;
          if (GB == 0) free_cyc = cyc + 3;
`else
          free_cyc = cyc + 2;
`endif
        end
      end
`ifdef SCHED_GAP_EN
      if ((GB > 0) && (gap_start >= 0) && (cyc >= gap_start) && (cyc < free_cyc) && beat && play) begin
        gap_cnt++;
        if (gap_cnt == GB) free_cyc = cyc + 1;
      end
`endif
    end
    cyc++;
  endtask

  task automatic step();
    bit hs;
    @(negedge clk);
    compare_outputs();
    model_step(hs);
    @(posedge clk);
    #1;
    if (hs) note_in_valid = 1'b0;
  endtask

  // Run n cycles with a beat every bp cycles (bp=0: none); refill queues that many duration-2 notes back to back.
  task automatic run(input int n, input int bp, input int refill);
    int left;
    left = refill;
    for (int k = 0; k < n; k++) begin
      if (!note_in_valid && (left > 0)) begin
        note_in_valid = 1'b1;
        note_in       = NW'($urandom);
        duration_in   = DW'(2);
        left--;
      end
      beat        = (bp > 0) && ((k % bp) == (bp - 1));
      sample_tick = ((k % 3) == 1);
      step();
    end
  endtask

  task automatic offer(input int nt, input int du);
    note_in_valid = 1'b1;
    note_in       = NW'(nt);
    duration_in   = DW'(du);
  endtask

  initial begin
    reset = 1'b0; play = 1'b1; beat = 1'b0; sample_tick = 1'b0;
    offer(20, 3);

    // Reset held with valid high, then the basic note plays on release.
    run(2, 0, 0);
    reset = 1'b1;
    run(32, 8, 0);

    // Zero-duration note is swallowed, then a 2-beat note plays.
    offer(5, 0);
    run(2, 0, 0);
    offer(9, 2);
    run(24, 8, 0);

    // Pause after the first of four beats while five beats go by.
    offer(11, 4);
    run(10, 8, 0);
    play = 1'b0;
    run(40, 8, 0);
    play = 1'b1;
    run(30, 8, 0);

    // Reset in the middle of a note with two beats left.
    offer(30, 4);
    run(17, 8, 0);
    reset = 1'b0;
    run(1, 0, 0);
    reset = 1'b1;
    run(5, 0, 0);

    // Back-to-back notes; exercises the gap when it is built in.
    run(80, 4, 3);

    // Random traffic.
    for (int k = 0; k < 4000; k++) begin
      reset         = ($urandom_range(0, 299) != 0);
      play          = ($urandom_range(0, 9) != 0);
      beat          = ($urandom_range(0, 3) == 0);
      sample_tick   = $urandom_range(0, 1) == 1;
      note_in_valid = $urandom_range(0, 1) == 1;
      note_in       = NW'($urandom);
      if ($urandom_range(0, 5) == 0)       duration_in = '0;
      else if ($urandom_range(0, 49) == 0) duration_in = DW'(EL_MAX);
      else                                 duration_in = DW'($urandom_range(1, 6));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
